// File: rtl/line_timing_gen_pkg.sv
// Shared definitions for the line timing generator.
//   state_t              : FSM state encoding (3-bit).
//   DEF_*                : default frame geometry (32 pixels, 4 blank cycles, 24 lines).
//   LINE_W               : width of the line index presented to the line counter side.
//   cnt_width()          : number of bits needed to hold 0..max_val (at least 1).
package line_timing_gen_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACTIVE = 3'd1,
    BLANK  = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int DEF_PIXELS_PER_LINE = 32;
  localparam int DEF_H_BLANK         = 4;
  localparam int DEF_LINES_PER_FRAME = 24;
  localparam int LINE_W              = 5;

  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    while ((1 << w) <= max_val) w++;
    return w;
  endfunction

endpackage

// File: rtl/line_timing_ctr.sv
// Terminal-count counter used for the pixel, blank and line positions.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (dominates en)
//   en       : advance by one; wraps to 0 after MAX so q never exceeds MAX
//   q        : current count, 0..MAX
//   last     : q == MAX
module line_timing_ctr #(
  parameter int W   = 5,
  parameter int MAX = 31
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         last
);

  localparam logic [W-1:0] LAST_Q = W'(MAX);

  assign last = (q == LAST_Q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= last ? '0 : q + W'(1);
    end
  end

endmodule

// File: rtl/line_timing_gen.sv
// Transmit-side line timing source. Walks each line through ACTIVE pixels,
// H_BLANK blanking cycles and a one-cycle CHECK, emitting a one-cycle newLine
// pulse toward the line counter and comparing the counter's endFrame with its
// own line index at the end of every line.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   enb        : enable; low returns to IDLE at the next edge (lineErr held)
//   start      : one-cycle frame request, accepted only in IDLE with enb=1
//   endFrame   : from line counter, high while its count is terminal
//   newLine    : one-cycle pulse in the last BLANK cycle of every line
//   pixValid   : high during active pixels
//   pixX       : active pixel index (0 outside ACTIVE)
//   lineIdx    : current line index
//   frameBusy  : high in every state except IDLE
//   frameDone  : one-cycle pulse in DONE
//   lineErr    : sticky frame-length mismatch flag
//   fsm_state  : current FSM state for observation
//
// Handshake: newLine carries no ready; the counter must take every pulse. Its
// registered response (endFrame) is only looked at in the CHECK cycle that
// follows the pulse, which absorbs the counter's one-cycle latency.
module line_timing_gen
  import line_timing_gen_pkg::*;
#(
  parameter int PIXELS_PER_LINE = DEF_PIXELS_PER_LINE,
  parameter int H_BLANK         = DEF_H_BLANK,
  parameter int LINES_PER_FRAME = DEF_LINES_PER_FRAME,
  parameter int PIX_W           = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enb,
  input  logic              start,
  input  logic              endFrame,
  output logic              newLine,
  output logic              pixValid,
  output logic [PIX_W-1:0]  pixX,
  output logic [LINE_W-1:0] lineIdx,
  output logic              frameBusy,
  output logic              frameDone,
  output logic              lineErr,
  output state_t            fsm_state
);

  localparam int BLANK_W = cnt_width(H_BLANK - 1);

  state_t             state;
  state_t             next_state;
  logic [BLANK_W-1:0] blank_q;
  logic               pix_last;
  logic               blank_last;
  logic               line_last;
  logic               accept;

  logic pix_valid_d;
  logic new_line_d;
  logic frame_busy_d;
  logic frame_done_d;
  logic line_err_d;

  assign fsm_state = state;
  assign accept    = (state == IDLE) && start && enb;

  // Position counters. Each is held at 0 outside its own state, so every
  // state is entered with a zeroed counter without extra load logic.
  line_timing_ctr #(.W(PIX_W), .MAX(PIXELS_PER_LINE - 1)) u_pix_ctr (
    .clk  (clk),
    .rst  (rst),
    .clr  (!enb || (state != ACTIVE)),
    .en   (state == ACTIVE),
    .q    (pixX),
    .last (pix_last)
  );

  line_timing_ctr #(.W(BLANK_W), .MAX(H_BLANK - 1)) u_blank_ctr (
    .clk  (clk),
    .rst  (rst),
    .clr  (!enb || (state != BLANK)),
    .en   (state == BLANK),
    .q    (blank_q),
    .last (blank_last)
  );

  // Line index survives through DONE so the closing line is still visible
  // alongside frameDone; it is cleared on the way into IDLE.
  line_timing_ctr #(.W(LINE_W), .MAX(LINES_PER_FRAME - 1)) u_line_ctr (
    .clk  (clk),
    .rst  (rst),
    .clr  (!enb || (state == IDLE) || (state == DONE)),
    .en   ((state == CHECK) && (next_state == ACTIVE)),
    .q    (lineIdx),
    .last (line_last)
  );

  // State register plus the registered Moore outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pixValid  <= 1'b0;
      newLine   <= 1'b0;
      frameBusy <= 1'b0;
      frameDone <= 1'b0;
      lineErr   <= 1'b0;
    end else begin
      state     <= next_state;
      pixValid  <= pix_valid_d;
      newLine   <= new_line_d;
      frameBusy <= frame_busy_d;
      frameDone <= frame_done_d;
      lineErr   <= line_err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    if (!enb) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) next_state = ACTIVE;
        ACTIVE:  if (pix_last) next_state = BLANK;
        BLANK:   if (blank_last) next_state = CHECK;
        CHECK:   next_state = (endFrame || line_last) ? DONE : ACTIVE;
        DONE:    next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Output logic, evaluated against the upcoming state so the registered
  // outputs line up with the state they describe.
  always_comb begin
    pix_valid_d  = (next_state == ACTIVE);
    frame_busy_d = (next_state != IDLE);
    frame_done_d = (next_state == DONE);
    new_line_d   = 1'b0;
    // newLine belongs to the final blank cycle: either BLANK is entered with a
    // single blank cycle, or the blank counter is one short of its last value.
    if (next_state == BLANK) begin
      if (state == ACTIVE) begin
        new_line_d = (H_BLANK == 1);
      end else begin
        new_line_d = (int'(blank_q) == H_BLANK - 2);
      end
    end
    line_err_d = lineErr;
    if (accept) begin
      line_err_d = 1'b0;
    end else if (enb && (state == CHECK) && (endFrame != line_last)) begin
      // Early end (endFrame before the last line) or missed end (last line
      // reached without endFrame).
      line_err_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_line_timing_gen.sv
module tb_line_timing_gen;
  import line_timing_gen_pkg::*;

  localparam int P     = 32;
  localparam int H     = 4;
  localparam int LINES = 24;
  localparam int PIX_W = 5;
  localparam int LP    = P + H + 1;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst;
  logic enb;
  logic start;
  logic end_frame;

  always #8 clk = ~clk;

  logic              new_line;
  logic              pix_valid;
  logic [PIX_W-1:0]  pix_x;
  logic [LINE_W-1:0] line_idx;
  logic              frame_busy;
  logic              frame_done;
  logic              line_err;
  state_t            fsm_state;

  line_timing_gen #(
    .PIXELS_PER_LINE (P),
    .H_BLANK         (H),
    .LINES_PER_FRAME (LINES),
    .PIX_W           (PIX_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enb       (enb),
    .start     (start),
    .endFrame  (end_frame),
    .newLine   (new_line),
    .pixValid  (pix_valid),
    .pixX      (pix_x),
    .lineIdx   (line_idx),
    .frameBusy (frame_busy),
    .frameDone (frame_done),
    .lineErr   (line_err),
    .fsm_state (fsm_state)
  );

  // Line counter environment: counts newLine pulses, clears when disabled or
  // when the bench launches a frame; endFrame is raised once the count
  // reaches end_at (0 = never).
  int         end_at;
  logic       cnt_clr;
  logic [5:0] cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (!enb || cnt_clr) cnt <= '0;
    else if (new_line) cnt <= cnt + 6'd1;
  end

  always_comb begin
    end_frame = 1'b0;
    end_frame = (end_at != 0) && (int'(cnt) == end_at);
  end

  // ---------------------------------------------------------------- scoreboard
  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic ev, input int ex, input logic enl,
                           input int eline, input logic ebusy, input logic edone,
                           input logic eerr);
    chk({tag, ".pixValid"}, 32'(pix_valid), 32'(ev));
    chk({tag, ".pixX"}, 32'(pix_x), ex);
    chk({tag, ".newLine"}, 32'(new_line), 32'(enl));
    chk({tag, ".lineIdx"}, 32'(line_idx), eline);
    chk({tag, ".frameBusy"}, 32'(frame_busy), 32'(ebusy));
    chk({tag, ".frameDone"}, 32'(frame_done), 32'(edone));
    chk({tag, ".lineErr"}, 32'(line_err), 32'(eerr));
  endtask

  // ---------------------------------------------------------------- driver
  // Runs one frame from a start pulse. Expected outputs come from cycle
  // arithmetic: each line is P pixels, H blank cycles and one check cycle.
  // abort_k > 0 ends the frame in cycle abort_k, by enb drop or by async reset.
  task automatic run_frame(input int end_at_v, input int abort_k, input logic by_rst,
                           input logic rand_start);
    int   nlines;
    logic err;
    int   n_cyc;
    int   nl_count;
    int   line;
    int   pos;
    end_at = end_at_v;
    if (end_at_v >= 1 && end_at_v <= LINES) begin
      nlines = end_at_v;
      err    = (end_at_v != LINES);
    end else begin
      nlines = LINES;
      err    = 1'b1;
    end
    n_cyc    = nlines * LP + 1;
    nl_count = 0;
    exp_q.delete();
    for (int l = 0; l < nlines; l++) exp_q.push_back(32'(l));

    start   = 1'b1;
    enb     = 1'b1;
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    cnt_clr = 1'b0;

    for (int k = 1; k <= n_cyc; k++) begin
      if (k < n_cyc) begin
        line = (k - 1) / LP;
        pos  = (k - 1) % LP;
        check_all("frame", pos < P, (pos < P) ? pos : 0, pos == P + H - 1, line, 1'b1, 1'b0, 1'b0);
        if (new_line === 1'b1) begin
          nl_count++;
          if (exp_q.size() > 0) chk("newline_line", 32'(line_idx), exp_q.pop_front());
          else chk("newline_extra", 32'(nl_count), 32'(nlines));
        end
      end else begin
        check_all("done", 1'b0, 0, 1'b0, nlines - 1, 1'b1, 1'b1, err);
      end

      if (k == abort_k) begin
        if (by_rst) begin
          #3 rst = 1'b1;
          #1 check_all("rst_async", 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
          @(posedge clk); #1;
          rst = 1'b0;
          check_all("rst_after", 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        end else begin
          enb = 1'b0;
          @(posedge clk); #1;
          check_all("enb_drop", 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
          // start with enb low must be ignored
          start = 1'b1;
          @(posedge clk); #1;
          start = 1'b0;
          @(posedge clk); #1;
          check_all("start_no_enb", 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
          enb = 1'b1;
        end
        return;
      end

      start = rand_start && (k < n_cyc) && ($urandom_range(0, 15) == 0);
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("newline_count", 32'(nl_count), 32'(nlines));
    check_all("idle_after", 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, err);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    rst     = 1'b1;
    enb     = 1'b0;
    start   = 1'b0;
    cnt_clr = 1'b0;
    end_at  = LINES;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    enb = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      check_all("idle", 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    end

    // nominal frame, early end, clean frame clearing lineErr, missing end
    run_frame(LINES, 0, 1'b0, 1'b0);
    run_frame(10, 0, 1'b0, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("err_hold_idle", 32'(line_err), 32'd1);
    end
    run_frame(LINES, 0, 1'b0, 1'b1);
    run_frame(0, 0, 1'b0, 1'b0);

    // lineErr held while disabled; start without enb ignored
    enb = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_all("enb_low_hold", 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    end
    start = 1'b0;
    enb = 1'b1;

    // disable at line 5, pixX 17
    run_frame(LINES, 5 * LP + 18, 1'b0, 1'b0);

    // set lineErr, then async reset in the middle of a blanking interval
    run_frame(3, 0, 1'b0, 1'b0);
    run_frame(LINES, 2 * LP + P + 2, 1'b1, 1'b1);
    run_frame(LINES, 0, 1'b0, 1'b0);

    // randomized frames: frame length, abort point, stray starts
    for (int r = 0; r < 6; r++) begin
      int ea;
      int ab;
      int len;
      ea  = $urandom_range(0, 30);
      len = (ea >= 1 && ea <= LINES) ? ea : LINES;
      ab  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, len * LP) : 0;
      run_frame(ea, ab, 1'b0, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
